// File: rtl/cipher_pkg.sv
// Shared state encodings, ASCII constants and letter helpers for the key/cipher controller.
package cipher_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_KEY  = 2'd1;
  localparam logic [1:0] S_CIPH = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_KEY  = S_KEY,
    ST_CIPH = S_CIPH
  } state_t;

  localparam logic [7:0] SPC_ASCII_CHAR = 8'd32;
  localparam logic [7:0] ASCII_A        = 8'd65;
  localparam logic [7:0] ASCII_Z        = 8'd90;
  localparam logic [7:0] ASCII_LA       = 8'd97;
  localparam logic [7:0] ASCII_LZ       = 8'd122;
  localparam logic [5:0] ALPHA_LEN      = 6'd26;

  function automatic logic is_alpha(input logic [7:0] c);
    return ((c >= ASCII_A) && (c <= ASCII_Z)) || ((c >= ASCII_LA) && (c <= ASCII_LZ));
  endfunction

  // Case-insensitive 0..25 offset; only meaningful when is_alpha(c).
  function automatic logic [4:0] alpha_off(input logic [7:0] c);
    return (c <= ASCII_Z) ? 5'(c - ASCII_A) : 5'(c - ASCII_LA);
  endfunction

endpackage

// File: rtl/vigenere_shift.sv
// Combinational Vigenere shift of one ASCII character; case preserved, non-letters pass through.
module vigenere_shift
  import cipher_pkg::*;
(
  input  logic [7:0] char_in,
  input  logic [4:0] shift,
  input  logic       decrypt,
  output logic [7:0] char_out,
  output logic       is_letter
);

  logic       w_upper;
  logic [7:0] w_base;
  logic [5:0] w_off;
  logic [5:0] w_shift;
  logic [5:0] w_sum;
  logic [5:0] w_dif;
  logic [5:0] w_res;

  always_comb begin
    w_upper   = (char_in >= ASCII_A) && (char_in <= ASCII_Z);
    is_letter = is_alpha(char_in);
    w_base    = w_upper ? ASCII_A : ASCII_LA;
    w_off     = 6'(char_in - w_base);
    w_shift   = {1'b0, shift};
    w_sum     = w_off + w_shift;
    if (w_sum >= ALPHA_LEN) w_sum = w_sum - ALPHA_LEN;
    w_dif     = (w_off < w_shift) ? (w_off + ALPHA_LEN - w_shift) : (w_off - w_shift);
    w_res     = decrypt ? w_dif : w_sum;
    char_out  = is_letter ? (w_base + {2'b00, w_res}) : char_in;
  end

endmodule

// File: rtl/key_cipher_ctrl.sv
// Captures a 1..KEY_LEN letter Vigenere key, then encrypts/decrypts each character with 1-cycle latency.
module key_cipher_ctrl
  import cipher_pkg::*;
#(
  parameter int KEY_LEN = 4,
  parameter int IDX_W   = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enter,
  input  logic             char_valid,
  input  logic [7:0]       char_in,
  input  logic             decrypt,
  output logic [7:0]       out_char,
  output logic             out_valid,
  output logic [1:0]       state,
  output logic [IDX_W-1:0] key_idx,
  output logic [IDX_W:0]   key_count
);

  localparam logic [IDX_W:0] LAST_CNT = (IDX_W + 1)'(KEY_LEN - 1);

  state_t           r_state;
  logic [4:0]       r_key [KEY_LEN];
  logic [IDX_W-1:0] r_key_idx;
  logic [IDX_W:0]   r_key_count;
  logic [7:0]       r_out_char;
  logic             r_out_valid;

  logic [7:0]       w_ciph_char;
  logic             w_ciph_letter;
  logic             w_key_letter;

  assign w_key_letter = is_alpha(char_in);

  vigenere_shift u_shift (
    .char_in   (char_in),
    .shift     (r_key[r_key_idx]),
    .decrypt   (decrypt),
    .char_out  (w_ciph_char),
    .is_letter (w_ciph_letter)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_key_idx   <= '0;
      r_key_count <= '0;
      r_out_char  <= SPC_ASCII_CHAR;
      r_out_valid <= 1'b0;
      for (int i = 0; i < KEY_LEN; i++) r_key[i] <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (enter) begin
            r_state     <= ST_KEY;
            r_key_idx   <= '0;
            r_key_count <= '0;
            for (int i = 0; i < KEY_LEN; i++) r_key[i] <= '0;
          end
        end
        ST_KEY: begin
          // A letter arriving with enter is captured before finalising.
          if (char_valid && w_key_letter) begin
            r_key[r_key_count[IDX_W-1:0]] <= alpha_off(char_in);
            r_key_count                   <= r_key_count + 1'b1;
            if (enter || (r_key_count == LAST_CNT)) begin
              r_state   <= ST_CIPH;
              r_key_idx <= '0;
            end
          end else if (enter && (r_key_count != '0)) begin
            r_state   <= ST_CIPH;
            r_key_idx <= '0;
          end
        end
        ST_CIPH: begin
          if (char_valid) begin
            r_out_valid <= 1'b1;
            r_out_char  <= w_ciph_char;
            if (w_ciph_letter) begin
              if ({1'b0, r_key_idx} == (r_key_count - 1'b1)) r_key_idx <= '0;
              else                                          r_key_idx <= r_key_idx + 1'b1;
            end
          end
          if (enter) begin
            r_state     <= ST_IDLE;
            r_key_idx   <= '0;
            r_key_count <= '0;
            for (int i = 0; i < KEY_LEN; i++) r_key[i] <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign state     = r_state;
  assign key_idx   = r_key_idx;
  assign key_count = r_key_count;
  assign out_char  = r_out_char;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_key_cipher_ctrl.sv
// Directed self-checking bench for key_cipher_ctrl with KEY_LEN=5.
module tb_key_cipher_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enter = 1'b0;
  logic       char_valid = 1'b0;
  logic [7:0] char_in = 8'd0;
  logic       decrypt = 1'b0;
  logic [7:0] out_char;
  logic       out_valid;
  logic [1:0] state;
  logic [2:0] key_idx;
  logic [3:0] key_count;

  int n_checks = 0;
  int n_fail   = 0;

  key_cipher_ctrl #(.KEY_LEN(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .enter      (enter),
    .char_valid (char_valid),
    .char_in    (char_in),
    .decrypt    (decrypt),
    .out_char   (out_char),
    .out_valid  (out_valid),
    .state      (state),
    .key_idx    (key_idx),
    .key_count  (key_count)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs; on return, outputs reflect the edge that sampled them.
  task automatic step(input logic v, input logic [7:0] c, input logic e);
    char_valid = v;
    char_in    = c;
    enter      = e;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    enter      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    n_checks++; if (out_char !== 8'd32) begin n_fail++; $display("FAIL reset_out_char got %0d want 32", out_char); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (key_idx !== 3'd0) begin n_fail++; $display("FAIL reset_key_idx got %0d want 0", key_idx); end
    n_checks++; if (key_count !== 4'd0) begin n_fail++; $display("FAIL reset_key_count got %0d want 0", key_count); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lemon();
    string key = "LEMON";
    string pt  = "ATTACKATDAWN";
    string ct  = "LXFOPVEFRNHR";
    decrypt = 1'b0;
    step(1'b0, 8'd0, 1'b1);
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL lemon_enter_key got %0d want 1", state); end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, key[i], 1'b0);
      n_checks++; if (key_count !== 4'(i + 1)) begin n_fail++; $display("FAIL lemon_count %0d got %0d want %0d", i, key_count, i + 1); end
      n_checks++; if (state !== ((i == 4) ? 2'd2 : 2'd1)) begin n_fail++; $display("FAIL lemon_key_state %0d got %0d", i, state); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lemon_key_strobe %0d got %b want 0", i, out_valid); end
    end
    n_checks++; if (key_idx !== 3'd0) begin n_fail++; $display("FAIL lemon_idx_entry got %0d want 0", key_idx); end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, pt[i], 1'b0);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lemon_valid %0d got %b want 1", i, out_valid); end
      n_checks++; if (out_char !== ct[i]) begin n_fail++; $display("FAIL lemon_char %0d got %h want %h", i, out_char, ct[i]); end
    end
    step(1'b0, 8'd0, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lemon_single_strobe got %b want 0", out_valid); end
    n_checks++; if (out_char !== 8'h52) begin n_fail++; $display("FAIL lemon_hold got %h want 52", out_char); end
    step(1'b0, 8'd0, 1'b1);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL lemon_exit got %0d want 0", state); end
  endtask

  task automatic test_early_key();
    string pt = "Hi, Z!";
    string ct = "Ij, A!";
    decrypt = 1'b0;
    step(1'b0, 8'd0, 1'b1);
    step(1'b1, 8'h62, 1'b0);
    n_checks++; if (state !== 2'd1 || key_count !== 4'd1) begin n_fail++; $display("FAIL early_key state %0d count %0d want 1 1", state, key_count); end
    step(1'b0, 8'd0, 1'b1);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL early_ciph got %0d want 2", state); end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, pt[i], 1'b0);
      n_checks++; if (out_valid !== 1'b1 || out_char !== ct[i]) begin n_fail++; $display("FAIL early_char %0d got %h/%b want %h/1", i, out_char, out_valid, ct[i]); end
      n_checks++; if (key_idx !== 3'd0) begin n_fail++; $display("FAIL early_idx %0d got %0d want 0", i, key_idx); end
    end
    step(1'b0, 8'd0, 1'b1);
  endtask

  task automatic test_decrypt();
    string pt = "ABAB";
    logic [2:0] idx_exp [4] = '{3'd1, 3'd0, 3'd1, 3'd0};
    step(1'b0, 8'd0, 1'b1);
    step(1'b1, 8'h43, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    step(1'b0, 8'd0, 1'b1);
    n_checks++; if (state !== 2'd2 || key_idx !== 3'd0) begin n_fail++; $display("FAIL dec_entry state %0d idx %0d want 2 0", state, key_idx); end
    decrypt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pt[i], 1'b0);
      n_checks++; if (out_valid !== 1'b1 || out_char !== 8'h59) begin n_fail++; $display("FAIL dec_char %0d got %h/%b want 59/1", i, out_char, out_valid); end
      n_checks++; if (key_idx !== idx_exp[i]) begin n_fail++; $display("FAIL dec_idx %0d got %0d want %0d", i, key_idx, idx_exp[i]); end
    end
    decrypt = 1'b0;
    step(1'b0, 8'd0, 1'b1);
  endtask

  task automatic test_simultaneous();
    step(1'b0, 8'd0, 1'b1);
    step(1'b1, 8'h42, 1'b0);
    step(1'b1, 8'h43, 1'b0);
    step(1'b1, 8'h4B, 1'b1);
    n_checks++; if (key_count !== 4'd3 || state !== 2'd2) begin n_fail++; $display("FAIL simul_key count %0d state %0d want 3 2", key_count, state); end
    step(1'b1, 8'h61, 1'b1);
    n_checks++; if (out_valid !== 1'b1 || out_char !== 8'h62) begin n_fail++; $display("FAIL simul_ciph got %h/%b want 62/1", out_char, out_valid); end
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL simul_idle got %0d want 0", state); end
    step(1'b0, 8'd0, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL simul_one_strobe got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    string pt = "abcdefgh";
    string ct = "zabcdefg";
    step(1'b0, 8'd0, 1'b1);
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, pt[i], 1'b0);
      n_checks++; if (out_valid !== 1'b1 || out_char !== ct[i]) begin n_fail++; $display("FAIL b2b_char %0d got %h/%b want %h/1", i, out_char, out_valid, ct[i]); end
    end
    reset      = 1'b0;
    char_valid = 1'b1;
    char_in    = 8'h78;
    @(posedge clk); #1;
    char_valid = 1'b0;
    reset      = 1'b1;
    n_checks++; if (state !== 2'd0 || out_char !== 8'd32 || out_valid !== 1'b0 || key_count !== 4'd0) begin
      n_fail++; $display("FAIL b2b_reset state %0d char %0d valid %b count %0d want 0 32 0 0", state, out_char, out_valid, key_count);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_trailing %0d got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_ignored();
    step(1'b1, 8'h78, 1'b0);
    n_checks++; if (state !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ign_idle state %0d valid %b want 0 0", state, out_valid); end
    step(1'b0, 8'd0, 1'b1);
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL ign_to_key got %0d want 1", state); end
    step(1'b0, 8'd0, 1'b1);
    n_checks++; if (state !== 2'd1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ign_empty_enter state %0d valid %b want 1 0", state, out_valid); end
    step(1'b1, 8'h35, 1'b0);
    n_checks++; if (key_count !== 4'd0 || state !== 2'd1) begin n_fail++; $display("FAIL ign_nonletter count %0d state %0d want 0 1", key_count, state); end
  endtask

  initial begin
    test_reset();
    test_lemon();
    test_early_key();
    test_decrypt();
    test_simultaneous();
    test_back_to_back();
    test_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_cipher_ctrl.md
# key_cipher_ctrl

Parametrised single-clock successor to the key-entry FSM and encryption datapath pair. It captures a Vigenère key of 1..KEY_LEN letters from the keyboard character stream, then encrypts or decrypts each following character with a registered 1-cycle latency. It sits between the keyboard decoder and the VGA character writer. It adds variable-length keys (early finalise with `enter`), a decrypt mode, case preservation and non-letter pass-through.

## Interface
- `KEY_LEN`, default 4: maximum key length in letters, at least 1.
- `IDX_W`, default `$clog2(KEY_LEN)` with a minimum of 1: width of the key index and count.
- `clk` in, 1: system clock (CLOCK_50). The only clock.
- `reset` in, 1: synchronous, active-low reset.
- `enter` in, 1: single-cycle pulse, already synchronised to `clk`. Advances the state.
- `char_valid` in, 1: single-cycle pulse; `char_in` is valid in this cycle.
- `char_in` in, 8: ASCII character from the keyboard.
- `decrypt` in, 1: 0 means encrypt, 1 means decrypt. Sampled with each `char_valid`.
- `out_char` out, 8: processed ASCII character for the VGA writer.
- `out_valid` out, 1: 1-cycle strobe; `out_char` is new in this cycle.
- `state` out, 2: current state (IDLE=0, KEY=1, CIPH=2).
- `key_idx` out, IDX_W: index of the next key letter to be used or written.
- `key_count` out, IDX_W+1: number of key letters captured or committed.

## Operation
- Reset values (`reset`=0 at a `clk` edge):
  - `state` = IDLE, `out_char` = 8'd32 (space), `out_valid` = 0.
  - `key_idx` = 0, `key_count` = 0, all key slots = 0.
  - Reset wins over every other input and applies in any state.
- Letter classification: `'A'..'Z'` (65..90) and `'a'..'z'` (97..122). Offset = char − base, giving 0..25. A key letter stores its 5-bit offset, case-insensitive.
- Arithmetic:
  - Encrypt: r = off + k, and if r ≥ 26 then r −= 26.
  - Decrypt: r = off − k, and if r < 0 then r += 26.
  - Output is base + r, so the input case is preserved. Use 6-bit intermediates; no other wrap.
- IDLE:
  - `enter` → KEY and clears the key slots and `key_count`.
  - `char_valid` is ignored.
- KEY:
  - On a letter with `char_valid`: slot[`key_count`] ← offset and `key_count`++.
  - If that letter is the KEY_LEN-th, the state goes to CIPH on the same edge.
  - Non-letters are ignored.
  - `enter` with `key_count` ≥ 1 → CIPH.
  - `enter` with `key_count` = 0 is ignored.
  - Simultaneous letter and `enter`: capture the letter first, then go to CIPH with the incremented count.
  - `key_idx` = 0 on entry to CIPH.
- CIPH:
  - Each `char_valid` produces exactly one `out_valid`.
  - A letter is shifted by slot[`key_idx`], then `key_idx` advances and wraps from `key_count`−1 to 0.
  - A non-letter passes through unchanged and `key_idx` holds.
  - `enter` → IDLE and clears the key.
  - Simultaneous `char_valid` and `enter`: the character is still processed and output, then the state goes to IDLE.
- `out_char` holds its last value between strobes.

## Timing
- Latency: `char_valid` in cycle t gives `out_char` and `out_valid` in cycle t+1. Throughput is one character per cycle; back-to-back `char_valid` is legal.
- State changes take effect on the `clk` edge where `enter` or the final key letter is sampled.
- `out_valid` is never high for two cycles from one input.
- No combinational path from any input to any output.
- Reset mid-operation aborts without a trailing `out_valid`.

## Structure
- Shared package `cipher_pkg`:
  - State localparams `S_IDLE`, `S_KEY`, `S_CIPH`.
  - ASCII constants `SPC_ASCII_CHAR`=32, `ASCII_A`=65, `ASCII_Z`=90, `ASCII_LA`=97, `ASCII_LZ`=122.
  - `ALPHA_LEN`=26.
- Sub-module `vigenere_shift`: purely combinational.
  - Inputs: `char_in`, 5-bit `shift`, `decrypt`.
  - Outputs: `char_out`, `is_letter`.
  - Instantiated once, for the CIPH path. The KEY path uses the same classification via the package constants.
- Top level: state register, key slot array (KEY_LEN × 5 bits), counters, output register.

## Test plan
- KEY_LEN=5:
  - Stimulus: `enter`, key "LEMON", then plaintext "ATTACKATDAWN" with `decrypt`=0.
  - Required: `out_char` sequence "LXFOPVEFRNHR", each one cycle after its input.
  - The state must reach CIPH on the 'N' edge with no `enter`.
- KEY_LEN=4, early key and non-letters:
  - Stimulus: key "b", `enter`, then "Hi, Z!".
  - Required: "Ij, A!".
  - The case is preserved, and `key_idx` stays at 0 throughout.
- Decrypt and wrap:
  - Stimulus: key "CD" with `decrypt`=1, input "ABAB".
  - Required: "YYYY".
  - `key_idx` must go 0,1,0,1,0.
- Simultaneous events:
  - `enter` together with 'K' in KEY with `key_count`=2: `key_count` becomes 3 and the state goes to CIPH.
  - `char_valid` together with `enter` in CIPH: one `out_valid`, then IDLE.
- Back-to-back and reset:
  - Stimulus: 8 consecutive `char_valid` pulses.
  - Required: 8 consecutive `out_valid` cycles.
  - Then `reset`=0 mid-stream: the next cycle shows IDLE, `out_char`=32, `out_valid`=0, `key_count`=0, and no further strobes.
- Ignored input: `enter` in KEY with `key_count`=0, and `char_valid` in IDLE, leave the state unchanged and produce no `out_valid`.
